game_state_link_tx: RTL
=======================

// Module: game_state_link_tx
// PURPOSE
//  Master-to-slave direction of the two-board link: serialises a game-state snapshot onto one
//  Pmod wire for the slave board. The slave-to-master direction carries the player-2 button lines.
//  Sits on the master board between game logic and the Pmod pin. Holds the line idle when the
//  board is not master.
// PARAMETERS
//  CLKS_PER_BIT   10417  clk cycles per serial bit (100 MHz / 9600 baud)
//  PAYLOAD_BYTES  4      game-state bytes per frame (1..15)
// PORTS
//  clk       in   1                  system clock, all logic on posedge
//  reset     in   1                  asynchronous, active-high reset
//  isMaster  in   1                  1 = this board is master; 0 = transmitter disabled
//  send      in   1                  request to transmit the current payload (level or pulse)
//  payload   in   8*PAYLOAD_BYTES    snapshot; byte k = payload[8k+7:8k]
//  busy      out  1                  1 while a frame is in flight
//  done      out  1                  one-cycle pulse after the last stop bit of a completed frame
//  tx        out  1                  serial line to slave, idle high
// BEHAVIOUR
//  - Reset values (async, immediate): tx=1, busy=0, done=0, state=IDLE, all counters 0.
//  - Frame = SYNC(0xA5), payload byte 0..PAYLOAD_BYTES-1, CHK. CHK is the XOR of all payload bytes.
//    SYNC is not included in CHK.
//  - Each byte = start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly
//    CLKS_PER_BIT cycles. No gap between bytes.
//  - Frame length = (PAYLOAD_BYTES+2)*10*CLKS_PER_BIT cycles.
//  - Accept: in IDLE, a posedge with send=1 and isMaster=1 accepts the request.
//    - payload is latched in that cycle. CHK is computed from the latched copy.
//    - busy=1 and tx=0 (SYNC start bit) from the next cycle.
//    - Latency: accept at cycle N, tx falls at cycle N+1.
//  - FSM: IDLE -> START -> DATA(8 bits) -> STOP.
//    - From STOP, if bytes remain, go to START; otherwise go to DONE (1 cycle), then IDLE.
//    - done=1 only in DONE. busy drops in the same cycle that done rises.
//  - send while busy is ignored; the payload is not re-latched.
//    - If send is still high in the IDLE cycle after DONE, it is accepted: back-to-back frames
//      with a one-cycle idle gap.
//  - isMaster=0 at any point (synchronous check):
//    - next cycle: tx=1, busy=0, state=IDLE, counters cleared;
//    - no done pulse is produced; the partial frame is abandoned.
//  - Reset mid-frame: tx returns high asynchronously and nothing resumes after reset releases.
//  - Bit counter: width clog2(CLKS_PER_BIT). Byte index: width 4. No wrap beyond PAYLOAD_BYTES+1.
//  - payload changes while busy have no effect on the frame in flight.
// STRUCTURE
//  - Shared header link_defs.vh:
//    - LINK_SYNC_BYTE = 8'hA5;
//    - state encodings IDLE/START/DATA/STOP/DONE;
//    - default CLKS_PER_BIT.
//    The slave-side receiver includes the same header.
//  - One sub-module: uart_byte_tx (bit-time counter + 10-bit shifter).
//    - Ports: clk, reset, start, data[7:0], tx, byte_done.
//    - The top FSM sequences bytes and selects SYNC / payload / CHK.
// TESTING (CLKS_PER_BIT=4, PAYLOAD_BYTES=2 unless noted)
//  - Reset then idle: tx=1, busy=0, done=0 for 50 cycles with send=0.
//  - isMaster=1, send pulse, payload=16'h3C12. Required:
//    - tx serialises A5,12,3C,2E (CHK = 12^3C);
//    - each bit lasts 4 cycles, LSB first;
//    - busy high for 160 cycles, done pulses once at cycle 161.
//  - Second send pulse at cycle 40 of the frame, with payload changed to 16'hFFFF.
//    Required: frame still carries 12,3C,2E; no second frame starts.
//  - isMaster=0 for the whole test, send pulsed. Required: tx stays 1, busy stays 0, no done.
//  - isMaster dropped at cycle 70 of a frame.
//    Required: tx=1 and busy=0 from cycle 71, no done; a later send with isMaster=1 sends a
//    full fresh frame.
//  - Async reset asserted mid-bit between clock edges.
//    Required: tx=1 before the next posedge; after release, idle until a new send.

Source files
------------

// File: rtl/game_state_link_tx_pkg.sv
// -----------------------------------------------------------------------------
// game_state_link_tx_pkg
// Definitions shared by the two-board link: the frame sync byte, the serial
// bit-phase encodings, the frame sequencer states and default timing.
// The slave-side receiver imports the same package so both ends agree on
// framing.
// No ports (package).
// -----------------------------------------------------------------------------
package game_state_link_tx_pkg;

    // First byte of every frame; lets the receiver find the frame boundary.
    localparam logic [7:0] LINK_SYNC_BYTE = 8'hA5;

    // 100 MHz system clock, 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT  = 10417;
    localparam int DEFAULT_PAYLOAD_BYTES = 4;

    // Bit phases of one serial byte. DONE is the post-frame marker shared with
    // the receiver; the byte serialiser itself never enters it.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } linkState_t;

    // Frame-level sequencing in the transmitter top.
    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_BODY,   // SYNC or a payload byte in flight
        FRAME_CHK,    // checksum byte in flight
        FRAME_DONE    // one-cycle completion pulse
    } frameState_t;

    // Counter width that stays legal when a bit lasts a single clock.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_state_link_tx_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte as start bit (0), 8 data bits LSB first, stop bit (1),
// each bit held CLKS_PER_BIT clocks.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   load data and begin a byte on the next cycle; also
//                   accepted in the last stop-bit cycle for gapless bytes
//   data[7:0]  in   byte to send, sampled when start=1
//   tx         out  serial line, idle high
//   byte_done  out  high during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_byte_tx
    import game_state_link_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done
);

    localparam int              CNT_W    = cntWidth(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    linkState_t       state;
    linkState_t       stateNext;
    logic [CNT_W-1:0] bitCnt;
    logic [2:0]       dataIdx;
    logic [9:0]       shifter;
    logic             bitEnd;

    assign bitEnd    = (bitCnt == CNT_LAST);
    assign byte_done = (state == STOP) && bitEnd;

    // The shifter's LSB is the line itself; it refills with ones so the line
    // rests high once the stop bit has shifted out.
    assign tx = shifter[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (start) begin
            stateNext = START;
        end else begin
            case (state)
                START:   if (bitEnd) stateNext = DATA;
                DATA:    if (bitEnd && dataIdx == 3'd7) stateNext = STOP;
                STOP:    if (bitEnd) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt  <= '0;
            dataIdx <= 3'd0;
            shifter <= '1;
        end else if (start) begin
            bitCnt  <= '0;
            dataIdx <= 3'd0;
            shifter <= {1'b1, data, 1'b0};
        end else if (state != IDLE) begin
            if (bitEnd) begin
                bitCnt  <= '0;
                shifter <= {1'b1, shifter[9:1]};
                // Wraps 7 -> 0 as DATA ends, ready for the next byte.
                if (state == DATA) begin
                    dataIdx <= dataIdx + 3'd1;
                end
            end else begin
                bitCnt <= bitCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_state_link_tx.sv
// -----------------------------------------------------------------------------
// game_state_link_tx
// Master-to-slave half of the two-board link. On request it latches a
// game-state snapshot and sends the frame SYNC(0xA5), payload bytes 0..N-1,
// CHK (XOR of the payload bytes) as back-to-back UART bytes on one Pmod wire.
// The line is held idle whenever the board is not master.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   isMaster  in   1 = this board drives the link; 0 aborts/disables sending
//   send      in   request to send the current payload (level or pulse)
//   payload   in   snapshot, byte k = payload[8k+7:8k]
//   busy      out  high while a frame is in flight
//   done      out  one-cycle pulse after the last stop bit of a full frame
//   tx        out  serial line to the slave, idle high
// -----------------------------------------------------------------------------
module game_state_link_tx
    import game_state_link_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       isMaster,
    input  logic                       send,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       busy,
    output logic                       done,
    output logic                       tx
);

    // byteIdx = next payload byte to send; reaching this value means only CHK
    // remains, which keeps the index within 4 bits for up to 15 payload bytes.
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES);

    frameState_t                frState;
    frameState_t                frNext;
    logic [3:0]                 byteIdx;
    logic [8*PAYLOAD_BYTES-1:0] payloadReg;
    logic                       accept;
    logic                       startByte;
    logic [7:0]                 byteData;
    logic                       byteDone;
    logic                       byteTx;
    logic [7:0]                 chk;

    function automatic logic [7:0] frameChk(input logic [8*PAYLOAD_BYTES-1:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            acc = acc ^ bytes[8*k +: 8];
        end
        return acc;
    endfunction

    assign chk = frameChk(payloadReg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frState <= FRAME_IDLE;
        end else begin
            frState <= frNext;
        end
    end

    always_comb begin
        frNext    = frState;
        accept    = 1'b0;
        startByte = 1'b0;
        byteData  = LINK_SYNC_BYTE;
        if (!isMaster) begin
            frNext = FRAME_IDLE;
        end else begin
            case (frState)
                FRAME_IDLE: begin
                    if (send) begin
                        accept    = 1'b1;
                        startByte = 1'b1;
                        frNext    = FRAME_BODY;
                    end
                end
                FRAME_BODY: begin
                    // Next byte is loaded in the final stop-bit cycle so
                    // bytes follow each other without a gap.
                    if (byteDone) begin
                        startByte = 1'b1;
                        if (byteIdx == LAST_IDX) begin
                            byteData = chk;
                            frNext   = FRAME_CHK;
                        end else begin
                            byteData = 8'(payloadReg >> {byteIdx, 3'b000});
                        end
                    end
                end
                FRAME_CHK: begin
                    if (byteDone) frNext = FRAME_DONE;
                end
                default: frNext = FRAME_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byteIdx <= 4'd0;
        end else if (!isMaster || accept) begin
            byteIdx <= 4'd0;
        end else if (frState == FRAME_BODY && byteDone && byteIdx != LAST_IDX) begin
            byteIdx <= byteIdx + 4'd1;
        end
    end

    // Snapshot register: only written on accept, so later payload changes
    // cannot disturb a frame in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            payloadReg <= payload;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) byteTxInst (
        .clk      (clk),
        .reset    (reset),
        .start    (startByte),
        .data     (byteData),
        .tx       (byteTx),
        .byte_done(byteDone)
    );

    assign busy = (frState == FRAME_BODY) || (frState == FRAME_CHK);
    assign done = (frState == FRAME_DONE);

    // After an abort the serialiser may still be finishing its byte; the line
    // is forced idle outside a frame so the slave never sees that tail.
    assign tx = busy ? byteTx : 1'b1;

endmodule
